// File: rtl/defunnel_pkg.sv
// defunnel_pkg: shared constants and config decode for the defunnel datapath
//   CHUNK_W_DEF : default narrow word width
//   PAD_BIT     : mode bit flagging a group closed early and zero padded
//   sat_ratio   : extracts the ratio field [log_chunks:0] and saturates it to log_chunks
package defunnel_pkg;
   localparam int CHUNK_W_DEF = 32;
   localparam int PAD_BIT = 7;
   function automatic logic [7:0] sat_ratio(input logic [7:0] cfg, input int log_chunks);
      logic [7:0] field;
      field = cfg & 8'((2 << log_chunks) - 1);
      return (int'(field) > log_chunks) ? 8'(log_chunks) : field;
   endfunction
endpackage

// File: rtl/defunnel_pack_acc.sv
// defunnel_pack_acc: lane accumulator holding the partial wide beat
//   clk, reset : clock, synchronous active-high reset
//   wr_en      : write wr_dat into lane wr_lane this cycle
//   clr        : drop the accumulated group on the next edge
//   acc_nxt    : accumulator merged with the word being written (next wide beat)
module defunnel_pack_acc
   import defunnel_pkg::*;
#(
   parameter int CHUNKS = 8,
   parameter int CHUNK_W = CHUNK_W_DEF,
   parameter int LOG_CHUNKS = $clog2(CHUNKS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [LOG_CHUNKS-1:0]     wr_lane,
   input  logic [CHUNK_W-1:0]        wr_dat,
   input  logic                      clr,
   output logic [CHUNKS*CHUNK_W-1:0] acc_nxt
);
   logic [CHUNKS*CHUNK_W-1:0] acc_q, acc_d;
   always_comb begin
      acc_nxt = acc_q;
      if (wr_en) acc_nxt[int'(wr_lane)*CHUNK_W +: CHUNK_W] = wr_dat;
      acc_d = clr ? '0 : acc_nxt;
   end
   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else acc_q <= acc_d;
   end
endmodule

// File: rtl/defunnel_pack.sv
// defunnel_pack: packs 1/2/4/8.. narrow words into one registered wide beat
//   clk, reset        : clock, synchronous active-high reset
//   cfg_ratio         : log2(words per beat), sampled at group start, saturated
//   t_dat/t_valid/t_ready : narrow input stream
//   t_last            : close the group early (only with DEFUNNEL_PACK_LAST_EN)
//   i_dat/i_valid/i_ready : registered wide output beat
//   enable            : one-hot lane strobe of the word accepted this cycle
//   mode              : latched group config {pad flag, ratio}
//   fill              : words held in the current partial group
// Optional feature macro: DEFUNNEL_PACK_LAST_EN
module defunnel_pack
   import defunnel_pkg::*;
#(
   parameter int CHUNKS = 8,
   parameter int CHUNK_W = CHUNK_W_DEF,
   parameter int LOG_CHUNKS = $clog2(CHUNKS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                cfg_ratio,
   input  logic [CHUNK_W-1:0]        t_dat,
   input  logic                      t_valid,
`ifdef DEFUNNEL_PACK_LAST_EN
   input  logic                      t_last,
`endif
   output logic                      t_ready,
   output logic [CHUNKS*CHUNK_W-1:0] i_dat,
   output logic                      i_valid,
   input  logic                      i_ready,
   output logic [CHUNKS-1:0]         enable,
   output logic [7:0]                mode,
   output logic [LOG_CHUNKS:0]       fill
);
   typedef logic [LOG_CHUNKS:0] cnt_t;
   cnt_t fill_q, fill_d, cur_ratio, last_idx;
   logic [7:0] mode_q, mode_d;
   logic i_valid_q, i_valid_d;
   logic [CHUNKS*CHUNK_W-1:0] i_dat_q, i_dat_d, acc_nxt;
   logic last_in, at_end, accept, complete;
`ifdef DEFUNNEL_PACK_LAST_EN
   assign last_in = t_last;
`else
   assign last_in = 1'b0;
`endif
   always_comb begin
      // the first word of a group uses the live cfg; later words use the latched one
      cur_ratio = (fill_q == '0) ? cnt_t'(sat_ratio(cfg_ratio, LOG_CHUNKS)) : cnt_t'(mode_q[LOG_CHUNKS:0]);
      last_idx = (cnt_t'(1) << cur_ratio) - cnt_t'(1);
      at_end = (fill_q == last_idx) | last_in;
      // only a completing word needs a free output register
      t_ready = !reset && !(i_valid_q && !i_ready && at_end);
      accept = t_valid & t_ready;
      complete = accept & at_end;
      enable = accept ? (CHUNKS'(1) << fill_q[LOG_CHUNKS-1:0]) : '0;
      fill_d = complete ? '0 : accept ? fill_q + cnt_t'(1) : fill_q;
      mode_d = accept ? {complete & (fill_q != last_idx), 7'(cur_ratio)} : mode_q;
      i_valid_d = complete | (i_valid_q & !i_ready);
      i_dat_d = complete ? acc_nxt : i_dat_q;
   end
   defunnel_pack_acc #(.CHUNKS(CHUNKS), .CHUNK_W(CHUNK_W), .LOG_CHUNKS(LOG_CHUNKS)) u_acc (
      .clk(clk),
      .reset(reset),
      .wr_en(accept),
      .wr_lane(fill_q[LOG_CHUNKS-1:0]),
      .wr_dat(t_dat),
      .clr(complete),
      .acc_nxt(acc_nxt)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_q <= '0;
         mode_q <= '0;
         i_valid_q <= 1'b0;
         i_dat_q <= '0;
      end else begin
         fill_q <= fill_d;
         mode_q <= mode_d;
         i_valid_q <= i_valid_d;
         i_dat_q <= i_dat_d;
      end
   end
   assign i_valid = i_valid_q;
   assign i_dat = i_dat_q;
   assign mode = mode_q;
   assign fill = fill_q;
endmodule

// File: tb/tb_defunnel_pack.sv
// tb_defunnel_pack: directed plus random stimulus against a word-queue reference model
module tb_defunnel_pack;
   localparam int CHUNKS = 8;
   localparam int LOG = 3;
   localparam int DW = CHUNKS * 32;
`ifdef DEFUNNEL_PACK_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic t_valid = 1'b0;
   logic i_ready = 1'b0;
   logic t_last = 1'b0;
   logic [7:0] cfg_ratio = '0;
   logic [31:0] t_dat = '0;
   logic t_ready, i_valid;
   logic [DW-1:0] i_dat;
   logic [CHUNKS-1:0] enable;
   logic [7:0] mode;
   logic [LOG:0] fill;
   int checks = 0;
   int errors = 0;
   logic [31:0] words[$];
   int grp_ratio = 0;
   logic m_valid = 1'b0;
   logic [DW-1:0] m_dat = '0;
   logic [7:0] m_mode = '0;

   always #5 clk = ~clk;

   defunnel_pack #(.CHUNKS(CHUNKS)) dut (
      .clk(clk),
      .reset(reset),
      .cfg_ratio(cfg_ratio),
      .t_dat(t_dat),
      .t_valid(t_valid),
`ifdef DEFUNNEL_PACK_LAST_EN
      .t_last(t_last),
`endif
      .t_ready(t_ready),
      .i_dat(i_dat),
      .i_valid(i_valid),
      .i_ready(i_ready),
      .enable(enable),
      .mode(mode),
      .fill(fill)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input logic [7:0] c);
      int f;
      f = int'(c) % (2 << LOG);
      return (f > LOG) ? LOG : f;
   endfunction

   task automatic model_reset();
      words.delete();
      grp_ratio = 0;
      m_valid = 1'b0;
      m_dat = '0;
      m_mode = '0;
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic [7:0] cfg, input logic last);
      int n, er, r;
      logic lastv, comp, exp_tr, acc;
      @(negedge clk);
      t_valid = v; t_dat = d; i_ready = rdy; cfg_ratio = cfg; t_last = last;
      #1;
      n = words.size();
      er = (n == 0) ? sat(cfg) : grp_ratio;
      r = 1 << er;
      lastv = LAST_EN && last;
      comp = (n == r - 1) || lastv;
      exp_tr = !(m_valid && !rdy && comp);
      acc = v && exp_tr;
      chk("t_ready", DW'(t_ready), DW'(exp_tr));
      chk("enable", DW'(enable), acc ? (DW'(1) << n) : '0);
      chk("i_valid", DW'(i_valid), DW'(m_valid));
      chk("i_dat", i_dat, m_dat);
      chk("mode", DW'(mode), DW'(m_mode));
      chk("fill", DW'(fill), DW'(n));
      if (m_valid && rdy) m_valid = 1'b0;
      if (acc) begin
         if (n == 0) grp_ratio = er;
         words.push_back(d);
         m_mode = {1'b0, 7'(er)};
         if (comp) begin
            m_dat = '0;
            foreach (words[k]) m_dat[k*32 +: 32] = words[k];
            m_valid = 1'b1;
            m_mode[7] = words.size() < r;
            words.delete();
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; t_valid = 1'b1;
      #1 chk("t_ready_in_reset", DW'(t_ready), '0);
      @(negedge clk);
      reset = 1'b0; t_valid = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [DW-1:0] beat;
      logic [7:0] cfg;
      do_reset();
      // basic pack, R=8
      for (int k = 1; k <= 8; k++) step(1'b1, 32'(k), 1'b1, 8'd3, 1'b0);
      step(1'b0, '0, 1'b1, 8'd3, 1'b0);
      beat = '0;
      for (int k = 0; k < 8; k++) beat[k*32 +: 32] = 32'(k + 1);
      chk("basic_beat", i_dat, beat);
      // R=2
      step(1'b1, 32'hA, 1'b1, 8'd1, 1'b0);
      step(1'b1, 32'hB, 1'b1, 8'd1, 1'b0);
      step(1'b1, 32'hC, 1'b1, 8'd1, 1'b0);
      step(1'b1, 32'hD, 1'b1, 8'd1, 1'b0);
      step(1'b0, '0, 1'b1, 8'd1, 1'b0);
      // backpressure, R=2
      step(1'b1, 32'h11, 1'b1, 8'd1, 1'b0);
      step(1'b1, 32'h12, 1'b0, 8'd1, 1'b0);
      step(1'b1, 32'h13, 1'b0, 8'd1, 1'b0);
      step(1'b1, 32'h14, 1'b0, 8'd1, 1'b0);
      step(1'b1, 32'h14, 1'b0, 8'd1, 1'b0);
      step(1'b1, 32'h14, 1'b1, 8'd1, 1'b0);
      step(1'b0, '0, 1'b1, 8'd1, 1'b0);
      step(1'b0, '0, 1'b1, 8'd1, 1'b0);
      // cfg change mid group, and saturation of an out-of-range ratio
      for (int k = 0; k < 3; k++) step(1'b1, 32'(k + 32'h20), 1'b1, 8'd3, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b1, 32'(k + 32'h30), 1'b1, 8'd1, 1'b0);
      for (int k = 0; k < 9; k++) step(1'b1, 32'(k + 32'h40), 1'b1, 8'd7, 1'b0);
      // ratio 0
      for (int k = 0; k < 3; k++) step(1'b1, 32'(k + 32'h50), 1'b1, 8'd0, 1'b0);
      // reset mid group
      for (int k = 0; k < 5; k++) step(1'b1, 32'(k + 32'h60), 1'b1, 8'd3, 1'b0);
      do_reset();
      for (int k = 0; k < 8; k++) step(1'b1, 32'(k + 32'h70), 1'b1, 8'd3, 1'b0);
      step(1'b0, '0, 1'b1, 8'd3, 1'b0);
`ifdef DEFUNNEL_PACK_LAST_EN
      for (int k = 0; k < 3; k++) step(1'b1, 32'(k + 32'h80), 1'b1, 8'd3, k == 2);
      step(1'b0, '0, 1'b1, 8'd3, 1'b0);
      chk("pad_flag", DW'(mode[7]), DW'(1));
      for (int k = 0; k < 8; k++) step(1'b1, 32'(k + 32'h90), 1'b1, 8'd3, k == 7);
      step(1'b0, '0, 1'b1, 8'd3, 1'b0);
      chk("no_pad_flag", DW'(mode[7]), '0);
`endif
      // random traffic
      cfg = 8'd2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) cfg = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 299) == 0) do_reset();
         step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6, cfg, $urandom_range(0, 9) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/defunnel_pack.md
Name: defunnel_pack

Overview:
- Upstream sequencer for the defunnel datapath: accepts a narrow 32-bit valid/ready word stream and packs 1, 2, 4 or 8 consecutive words into one wide beat of CHUNKS*32 bits.
- Drives the per-lane write-enable vector and the config byte consumed by the defunnel data stage.
- Also provides its own registered wide output with valid/ready, so it works standalone.

Parameters:
- CHUNKS, 8, number of 32-bit lanes in the wide beat; power of two, 2..16.
- CHUNK_W, 32, narrow word width in bits.
- LOG_CHUNKS, $clog2(CHUNKS), derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_ratio  in  8  bits [LOG_CHUNKS:0] give log2(words per beat), 0..LOG_CHUNKS; upper bits ignored.
- t_dat  in  CHUNK_W  narrow data word.
- t_valid  in  1  narrow word valid.
- t_ready  out  1  narrow word accepted when t_valid & t_ready.
- i_dat  out  CHUNKS*CHUNK_W  packed wide beat; word k of a group sits in lane k (bits [32k+31:32k]).
- i_valid  out  1  wide beat valid.
- i_ready  in  1  downstream accepts the wide beat.
- enable  out  CHUNKS  one-hot lane-write strobe for the defunnel data stage; bit k high in the cycle word k is accepted.
- mode  out  8  latched group config {zero-pad, ratio}; stable for the whole group.
- fill  out  LOG_CHUNKS+1  number of words held in the current partial group.

Behaviour:
- Reset values: t_ready=0 during reset, 1 afterwards; i_valid=0; i_dat=0; enable=0; mode=0; fill=0; internal lane accumulator cleared.
- Group start (fill==0): cfg_ratio is sampled into mode on the first accepted word. R = 1<<mode[LOG_CHUNKS:0]. A cfg change mid-group is ignored until the next group.
- Out-of-range ratio (>LOG_CHUNKS) saturates to LOG_CHUNKS.
- Accept (t_valid & t_ready): word written to accumulator lane fill; enable[fill]=1 (combinational, same cycle); fill increments.
- Completion, when the accepted word is number R-1:
  - On the following edge, i_dat loads the accumulator merged with the current word; lanes >= R are zero.
  - i_valid is set, fill returns to 0, and the accumulator clears.
  - Latency: last word accepted at edge N gives i_valid high from edge N.
- Output register clears i_valid when i_valid & i_ready and no new completion occurs in the same cycle.
- Simultaneous drain and completion: i_dat reloads and i_valid stays 1, giving full throughput of one wide beat per R words.
- Backpressure: t_ready = !(i_valid & !i_ready & completing_word_pending).
  - Non-completing words are always accepted.
  - Only word R-1 stalls while the output register is full and undrained.
- Ratio 0 (R=1): every accepted word completes immediately; wide beat carries lane 0 only.
- Reset mid-group: partial words are discarded, no i_valid emitted, and the next group re-samples cfg_ratio.
- i_dat holds its value while i_valid & !i_ready (stable-under-stall rule).

Optional Feature:
- Macro DEFUNNEL_PACK_LAST_EN.
- When defined:
  - Adds input t_last (1 bit).
  - An accepted word with t_last completes the group early; remaining lanes are zero.
  - mode[7] is set to 1 for that beat, flagging it as padded.
  - t_last on word R-1 behaves as normal completion with mode[7]=0.
- When undefined: no t_last port, mode[7] is always 0, and groups complete only at R words.

Decomposition:
- Shared package defunnel_pkg: CHUNK_W default, cfg bit-field positions (ratio field, pad flag bit 7), saturating ratio decode function.
- One sub-module is natural: defunnel_pack_acc, holding the lane accumulator with per-lane enable and clear, and producing the merged next-beat vector.
- Counter, handshake and output register stay in the top.

Test Plan:
- Basic pack: CHUNKS=8, cfg_ratio=3, i_ready=1, words 0x1..0x8 back-to-back -> single i_valid beat with lane k = k+1; enable walks 0x01..0x80; t_ready constantly 1.
- Ratio 1 (R=2): words 0xA,0xB,0xC,0xD -> two beats {0,...,0xB,0xA} and {0,...,0xD,0xC}, upper six lanes zero, i_valid 1 cycle each.
- Backpressure: R=2, i_ready=0 after first beat -> third word accepted, fourth word sees t_ready=0, first beat's i_dat is held stable; raising i_ready -> fourth word accepted in the same cycle, next beat valid the following cycle.
- Mid-group cfg change: cfg_ratio 3 -> 1 after word 3 of an R=8 group -> that group still completes at 8 words; the next group completes at 2.
- Reset mid-group: assert reset after 5 of 8 words, then send 8 words -> exactly one beat containing only the post-reset words; fill returns to 0.
- DEFUNNEL_PACK_LAST_EN: R=8, t_last on word 3 -> beat with lanes 0..2 filled, lanes 3..7 zero, mode[7]=1; next group mode[7]=0.
